// File: rtl/demux8_pkg.sv
// ============================================================================
// demux8_pkg : shared widths, state encoding and bit-position mapping
// Rev 1.0
// ============================================================================
`default_nettype none

package demux8_pkg;

    localparam int SEL_W = 3;
    localparam int NBITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } demux8_state_t;

    // Maps serial bit index k onto its position in the parallel byte.
    function automatic logic [SEL_W-1:0] pos_of(input logic [SEL_W-1:0] k,
                                                input logic             lsb_first);
        return lsb_first ? k : (SEL_W'(NBITS - 1) - k);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux8_dec.sv
// ============================================================================
// demux8_dec : 3-to-8 one-hot write-strobe decoder, gated by enable
// Rev 1.0
// ============================================================================
`default_nettype none

module demux8_dec
    import demux8_pkg::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] idx,
    output logic [NBITS-1:0] we
);

    always_comb begin
        we = '0;
        if (en) begin
            we[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux8_s2p.sv
// ============================================================================
// demux8_s2p : serial-to-parallel 1-to-8 collector with valid strobe.
// Optional even-parity check enabled by defining DEMUX8_PARITY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module demux8_s2p
    import demux8_pkg::*;
#(
    parameter logic LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic             start,
    input  logic             din,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [NBITS-1:0] out,
    output logic             valid
`ifdef DEMUX8_PARITY_EN
    ,
    output logic             perr
`endif
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_COLLECT = ST_COLLECT;
    localparam logic [1:0] S_PARITY  = ST_PARITY;

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [NBITS-1:0] r_shadow;
    logic [NBITS-1:0] r_out;
    logic             r_valid;
    logic             r_busy;
`ifdef DEMUX8_PARITY_EN
    logic             r_perr;
`endif

    logic             w_last;
    logic             w_restart;
    logic             w_cap;
    logic [SEL_W-1:0] w_idx;
    logic [NBITS-1:0] w_we;
    logic [NBITS-1:0] w_shadow_base;
    logic [NBITS-1:0] w_shadow_next;

    // A start coinciding with the bit-7 capture is ignored so that frame completes.
    assign w_last    = (r_state == S_COLLECT) && (r_sel == SEL_W'(NBITS - 1));
    assign w_restart = EN && start && !w_last;
    assign w_cap     = w_restart || (EN && (r_state == S_COLLECT));
    assign w_idx     = pos_of(w_restart ? '0 : r_sel, LSB_FIRST);

    demux8_dec u_dec (
        .en  (w_cap),
        .idx (w_idx),
        .we  (w_we)
    );

    assign w_shadow_base = w_restart ? '0 : r_shadow;
    assign w_shadow_next = (w_shadow_base & ~w_we) | ({NBITS{din}} & w_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_shadow <= '0;
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef DEMUX8_PARITY_EN
            r_perr   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef DEMUX8_PARITY_EN
            r_perr  <= 1'b0;
`endif
            if (EN) begin
                if (w_cap) begin
                    r_shadow <= w_shadow_next;
                end
                if (w_restart) begin
                    r_state <= S_COLLECT;
                    r_sel   <= SEL_W'(1);
                    r_busy  <= 1'b1;
                end else begin
                    case (r_state)
                        S_IDLE: ;
                        S_COLLECT: begin
                            if (w_last) begin
                                r_sel <= '0;
`ifdef DEMUX8_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_out   <= w_shadow_next;
                                r_valid <= 1'b1;
`endif
                            end else begin
                                r_sel <= r_sel + SEL_W'(1);
                            end
                        end
                        S_PARITY: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
`ifdef DEMUX8_PARITY_EN
                            // Even parity: data bits plus parity bit must XOR to zero.
                            if (^{r_shadow, din} == 1'b0) begin
                                r_out   <= r_shadow;
                                r_valid <= 1'b1;
                            end else begin
                                r_perr  <= 1'b1;
                            end
`endif
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign sel   = r_sel;
    assign busy  = r_busy;
    assign out   = r_out;
    assign valid = r_valid;
`ifdef DEMUX8_PARITY_EN
    assign perr  = r_perr;
`endif

endmodule

`default_nettype wire

// File: doc/demux8_s2p.md
# demux8_s2p

Serial-to-parallel 1-to-8 demultiplexing collector. It is the receiving end of the 8-to-1 selector path. A serial bit stream, one bit per enabled clock, is steered by an internal 3-bit select counter into bit positions 0..7 of a holding register. The completed byte is presented on `out` with a one-cycle `valid` strobe. It sits after the 8-to-1 selector when that selector is scanned by a counter to serialise a byte.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 steers the first serial bit to `out[0]`; 0 steers it to `out[7]`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `EN`, input, 1: enable, active high. Low freezes all state.
- `start`, input, 1: frame start. Qualified by `EN`. The cycle that asserts it carries bit 0.
- `din`, input, 1: serial data bit.
- `sel`, output, 3: current steering position, equal to the counter value.
- `busy`, output, 1: high while a frame is being collected.
- `out`, output, 8: last completed byte.
- `valid`, output, 1: one-cycle pulse when `out` updates.
- `perr`, output, 1: only when `DEMUX8_PARITY_EN` is defined. One-cycle pulse on parity mismatch.

## Operation
- Reset values: state IDLE, `sel`=0, `busy`=0, `out`=8'h00, `valid`=0, `perr`=0, shadow register 8'h00.
- States: IDLE, COLLECT, and PARITY (PARITY only with the macro).
- IDLE:
  - On `EN`&`start`: write `din` into shadow[pos(0)], set `sel`=1, go to COLLECT.
  - Otherwise hold.
- COLLECT:
  - On `EN`=1: write `din` into shadow[pos(`sel`)], then increment `sel`.
  - When `sel`==7 is written: without the macro, load `out` from the shadow with bit 7 included, pulse `valid`, wrap `sel` to 0 and go to IDLE. With the macro, go to PARITY.
- Position mapping: pos(k)=k when `LSB_FIRST`=1, pos(k)=7-k when `LSB_FIRST`=0.
- `EN`=0 in any state:
  - No capture, no count, no state change.
  - `valid` and `perr` are 0.
  - `out` holds.
- `start` while in COLLECT or PARITY restarts the frame. The current `din` becomes bit 0, `sel`=1, the partial shadow is discarded, and no `valid` is issued.
- `start` in the same cycle as the bit-7 capture: the completing frame finishes first. `out` and `valid` update, and `start` is ignored for that cycle.
- `out` changes only on a completed frame. It is never partially updated.
- Asynchronous reset mid-frame returns every output immediately to its reset value. The partial frame is lost.

## Timing
- `start` at edge t with `EN` held high: bits are captured at edges t..t+7. `out` and `valid` are valid in the cycle after edge t+7, i.e. 8 cycles of latency.
- `EN` low cycles stretch the latency one-for-one.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle `valid` rises.
- Back-to-back frames: a new `start` is accepted the cycle after `valid`, giving a minimum frame period of 8 cycles (9 with parity).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `DEMUX8_PARITY_EN` defined:
  - After bit 7, one extra enabled cycle samples `din` as an even-parity bit.
  - If XOR of the 8 data bits and the parity bit is 0: `out` updates and `valid` pulses.
  - Otherwise: `out` holds, `perr` pulses, `valid` stays 0.
  - The `perr` port exists.
- Not defined: no PARITY state and no `perr` port. The frame completes on bit 7.

## Structure
- Package `demux8_pkg`:
  - `SEL_W`=3 and `NBITS`=8.
  - State enum `demux8_state_t` with IDLE, COLLECT, PARITY.
  - Position-mapping function `pos_of(k, lsb_first)`.
- Sub-module `demux8_dec`: combinational 3-to-8 one-hot decoder gated by `EN`. It produces the per-bit write strobes for the shadow register.

## Test plan
- Reset, then `EN`=1, `start` at cycle 0, `din` sequence 1,0,1,1,0,0,1,0 with `LSB_FIRST`=1 → `out`=8'h4D and `valid` high in cycle 8 only.
- Same stream with `LSB_FIRST`=0 → `out`=8'hB2.
- Same stream with `EN` low for 3 cycles after bit 3 → `out`=8'h4D, `valid` at cycle 11, `sel` frozen at 4 during the gap.
- Frame 8'hFF in progress, `start` reasserted at bit 5, then bits of 8'h0F → only one `valid`, `out`=8'h0F.
- `rst_n` asserted at bit 4 of a frame → `out`=8'h00, `sel`=0, `busy`=0 immediately. A following full frame of 8'hA5 completes normally.
- With `DEMUX8_PARITY_EN`: 8'h03 with parity bit 0 → `valid`, `out`=8'h03. 8'h07 with parity bit 0 → `perr` pulse, `out` stays 8'h03.
